timer_bank_ctrl: RTL and testbench
==================================

Name: timer_bank_ctrl

Overview:
- Bus-side controller for a bank of N periodic 24-bit timer channels.
- Decodes a byte-wide CPU register window per channel and drives each timer's preset and control inputs.
- Reads back each timer's current value and interrupt status, and pulses each channel's interrupt-clear input.
- Arbitrates the channel interrupts into a single prioritised CPU interrupt request with vector output and IACK freeze.

Parameters:
- CH_BITS, 2, log2 of channel count; N = 2**CH_BITS channels.
- VEC_BASE, 8'h40, interrupt vector for channel 0; channel c presents VEC_BASE + c.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- cs_n  in  1  register-window select, active low, held for the whole access.
- rw  in  1  1 = read, 0 = write.
- addr  in  CH_BITS+3  {channel, byte offset}.
- din  in  8  write data.
- dout  out  8  read data.
- dtack_n  out  1  access acknowledge, active low.
- tmr_preset  out  24*N  per-channel preset; channel c occupies bits [24c+23:24c].
- tmr_ctrl  out  8*N  per-channel control byte; bit 0 = enable.
- tmr_value  in  24*N  per-channel current count.
- tmr_int_n  in  N  per-channel interrupt flag, active low.
- tmr_rst_int_n  out  N  per-channel interrupt clear, active low.
- irq_n  out  1  combined interrupt request, active low.
- irq_vec  out  8  vector of the granted channel.
- iack_n  in  1  CPU interrupt acknowledge, active low.

Behaviour:
- Register map per channel (byte offset):
  - 0: control. Read returns {~tmr_int_n[c], ctrl[6:0]}; write sets ctrl[7:0] <= din.
  - 1/2/3: preset bits [23:16]/[15:8]/[7:0], read/write.
  - 4: reserved; reads 8'h00, writes ignored.
  - 5/6/7: value bits [23:16]/[15:8]/[7:0], read-only; writes ignored.
- Bus FSM states IDLE, ACCESS, DONE.
  - IDLE -> ACCESS when cs_n is sampled low.
  - ACCESS: write committed exactly once; read data registered into dout. Always goes to DONE.
  - DONE: dtack_n = 0. Stays while cs_n = 0; returns to IDLE when cs_n is sampled high, with dtack_n = 1 in the same edge.
  - dtack_n falls 2 clk edges after cs_n is first sampled low.
  - cs_n deasserted in ACCESS: the access still completes, then the FSM returns to IDLE on the next edge.
- Preset bytes update independently and immediately. No shadowing; software disables the channel before reloading.
- Interrupt clear: any write to offset 0 drives tmr_rst_int_n[c] low for exactly one clk cycle, starting the edge after ACCESS. All other bits stay 1.
- Arbiter:
  - pending = ~tmr_int_n, registered once.
  - irq_n = ~|pending_r.
  - Grant = lowest-numbered pending channel (channel 0 highest priority); irq_vec = VEC_BASE + grant.
  - While iack_n = 0, irq_vec and the grant are frozen. irq_n still tracks pending.
  - Grant updates the cycle after iack_n rises.
  - No pending channels: irq_vec holds its last value.
- Simultaneous events:
  - A control write and a new timer interrupt in the same cycle: the clear pulse still issues, and the timer determines the flag afterwards.
  - A CPU access and an IACK in the same cycle are independent.
- Reset (asynchronous) forces:
  - FSM -> IDLE; dout = 8'h00; dtack_n = 1.
  - All presets 0; all ctrl 0, so every channel is disabled.
  - tmr_rst_int_n all 1; irq_n = 1; irq_vec = VEC_BASE.
  - A reset mid-access aborts the access with no write committed.
- Width rules: irq_vec add is 8-bit, wrapping modulo 256.

Optional Feature:
- Macro: TIMER_BANK_CTRL_SNAPSHOT_EN.
- Defined:
  - A read of offset 5 latches all 24 bits of tmr_value[c] into a per-bank snapshot register and returns bits [23:16].
  - Offsets 6/7 return the snapshot's bits [15:8]/[7:0], giving a coherent 24-bit read.
  - One snapshot register is shared by all channels; the snapshot resets to 0.
- Undefined: offsets 5/6/7 return live tmr_value bytes sampled in ACCESS, and no snapshot register exists.

Test Plan:
- Reset, then read ch0 offsets 0..7 -> 8'h00 each; dtack_n low exactly 2 edges after cs_n low; irq_n = 1; irq_vec = 8'h40.
- Write ch2 offsets 1/2/3 = 12/34/56 and offset 0 = 8'h01:
  - tmr_preset[71:48] = 24'h123456; tmr_ctrl[23:16] = 8'h01.
  - tmr_rst_int_n[2] low for exactly 1 cycle; other channels untouched.
- Drive tmr_int_n = 4'b0101 (ch1, ch3 pending):
  - Two edges later irq_n = 0, irq_vec = 8'h41.
  - Read ch1 offset 0 with ctrl = 8'h01 -> 8'h81.
- Hold iack_n low; release ch1 and assert ch0 -> irq_vec stays 8'h41; after iack_n rises, irq_vec = 8'h40 on the next cycle.
- Assert rst_n low while the FSM is in ACCESS for a ch3 offset 1 write of 8'hAA -> tmr_preset ch3 stays 0 and dtack_n stays 1.
- With the snapshot macro defined:
  - Set ch1 tmr_value = 24'hABCDEF and read offset 5 -> 8'hAB.
  - Change tmr_value to 24'h000000, then read offsets 6/7 -> 8'hCD/8'hEF.
  - Without the macro, the same sequence returns 8'h00/8'h00.

Source files
------------

// File: rtl/timer_bank_ctrl.sv
// Bus-side controller for a bank of 2**CH_BITS 24-bit timer channels with a prioritised interrupt arbiter.
// Optional macro TIMER_BANK_CTRL_SNAPSHOT_EN adds a shared snapshot register for coherent 24-bit value reads.
module timer_bank_ctrl #(
  parameter int unsigned CH_BITS  = 2,
  parameter logic [7:0]  VEC_BASE = 8'h40
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cs_n,
  input  logic                          rw,
  input  logic [CH_BITS+2:0]            addr,
  input  logic [7:0]                    din,
  output logic [7:0]                    dout,
  output logic                          dtack_n,
  output logic [24*(2**CH_BITS)-1:0]    tmr_preset,
  output logic [8*(2**CH_BITS)-1:0]     tmr_ctrl,
  input  logic [24*(2**CH_BITS)-1:0]    tmr_value,
  input  logic [(2**CH_BITS)-1:0]       tmr_int_n,
  output logic [(2**CH_BITS)-1:0]       tmr_rst_int_n,
  output logic                          irq_n,
  output logic [7:0]                    irq_vec,
  input  logic                          iack_n
);

  localparam int unsigned N  = 2**CH_BITS;
  localparam int unsigned TW = 24;
  localparam int unsigned AW = CH_BITS + 3;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 w_wr_en;
  logic                 w_rd_en;
  logic                 w_dtack_nxt_n;
  logic [CH_BITS-1:0]   w_ch;
  logic [2:0]           w_off;
  logic [TW-1:0]        w_value;
  logic [7:0]           w_rd_data;
  logic [CH_BITS-1:0]   w_grant;
  logic                 w_any;

  logic [7:0]           r_dout;
  logic                 r_dtack_n;
  logic [TW-1:0]        r_preset [N];
  logic [7:0]           r_ctrl   [N];
  logic [N-1:0]         r_rst_int_n;
  logic [N-1:0]         r_pending;
  logic                 r_irq_n;
  logic [7:0]           r_irq_vec;

  assign w_ch    = addr[AW-1:3];
  assign w_off   = addr[2:0];
  assign w_value = tmr_value[32'(w_ch)*TW +: TW];

  // Bus FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Bus FSM: next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (!cs_n) w_state_nxt = S_ACCESS;
      S_ACCESS: w_state_nxt = S_DONE;
      S_DONE:   if (cs_n) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Bus FSM: decoded strobes; dtack tracks the state being entered so it is registered with it
  always_comb begin
    w_wr_en       = 1'b0;
    w_rd_en       = 1'b0;
    w_dtack_nxt_n = (w_state_nxt != S_DONE);
    if (r_state == S_ACCESS) begin
      w_wr_en = ~rw;
      w_rd_en = rw;
    end
  end

`ifdef TIMER_BANK_CTRL_SNAPSHOT_EN
  logic [TW-1:0] r_snap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         r_snap <= '0;
    else if (w_rd_en && w_off == 3'd5)  r_snap <= w_value;
  end
`endif

  // Read data mux
  always_comb begin
    w_rd_data = 8'h00;
    case (w_off)
      3'd0: w_rd_data = {~tmr_int_n[w_ch], r_ctrl[w_ch][6:0]};
      3'd1: w_rd_data = r_preset[w_ch][23:16];
      3'd2: w_rd_data = r_preset[w_ch][15:8];
      3'd3: w_rd_data = r_preset[w_ch][7:0];
      3'd5: w_rd_data = w_value[23:16];
`ifdef TIMER_BANK_CTRL_SNAPSHOT_EN
      3'd6: w_rd_data = r_snap[15:8];
      3'd7: w_rd_data = r_snap[7:0];
`else
      3'd6: w_rd_data = w_value[15:8];
      3'd7: w_rd_data = w_value[7:0];
`endif
      default: w_rd_data = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dout    <= 8'h00;
      r_dtack_n <= 1'b1;
    end else begin
      r_dtack_n <= w_dtack_nxt_n;
      if (w_rd_en) r_dout <= w_rd_data;
    end
  end

  // Register writes and the one-cycle interrupt-clear pulse on control writes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(N); i++) begin
        r_preset[i] <= '0;
        r_ctrl[i]   <= '0;
      end
      r_rst_int_n <= '1;
    end else begin
      r_rst_int_n <= '1;
      if (w_wr_en) begin
        case (w_off)
          3'd0: begin
            r_ctrl[w_ch]      <= din;
            r_rst_int_n[w_ch] <= 1'b0;
          end
          3'd1:    r_preset[w_ch][23:16] <= din;
          3'd2:    r_preset[w_ch][15:8]  <= din;
          3'd3:    r_preset[w_ch][7:0]   <= din;
          default: ;
        endcase
      end
    end
  end

  // Lowest-numbered pending channel wins
  always_comb begin
    w_grant = '0;
    w_any   = |r_pending;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (r_pending[i]) w_grant = CH_BITS'(i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= '0;
      r_irq_n   <= 1'b1;
      r_irq_vec <= VEC_BASE;
    end else begin
      r_pending <= ~tmr_int_n;
      r_irq_n   <= ~|r_pending;
      if (iack_n && w_any) r_irq_vec <= VEC_BASE + 8'(w_grant);
    end
  end

  for (genvar g = 0; g < int'(N); g++) begin : g_flat
    assign tmr_preset[g*TW +: TW] = r_preset[g];
    assign tmr_ctrl[g*8 +: 8]     = r_ctrl[g];
  end

  assign dout          = r_dout;
  assign dtack_n       = r_dtack_n;
  assign tmr_rst_int_n = r_rst_int_n;
  assign irq_n         = r_irq_n;
  assign irq_vec       = r_irq_vec;

endmodule

// File: tb/tb_timer_bank_ctrl.sv
// Self-checking bench for timer_bank_ctrl: directed steps plus randomized traffic against a behavioural model.
module tb_timer_bank_ctrl;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst_n, cs_n, rw, iack_n;
  logic [4:0]  addr;
  logic [7:0]  din, dout, irq_vec;
  logic        dtack_n, irq_n;
  logic [95:0] tmr_preset, tmr_value;
  logic [31:0] tmr_ctrl;
  logic [3:0]  tmr_int_n, tmr_rst_int_n;

  timer_bank_ctrl #(.CH_BITS(2), .VEC_BASE(8'h40)) dut (
    .clk(clk), .rst_n(rst_n), .cs_n(cs_n), .rw(rw), .addr(addr), .din(din),
    .dout(dout), .dtack_n(dtack_n), .tmr_preset(tmr_preset), .tmr_ctrl(tmr_ctrl),
    .tmr_value(tmr_value), .tmr_int_n(tmr_int_n), .tmr_rst_int_n(tmr_rst_int_n),
    .irq_n(irq_n), .irq_vec(irq_vec), .iack_n(iack_n)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  int unsigned pulse_cnt [N] = '{default: 0};

  // Count clear-pulse low cycles per channel
  always @(negedge clk)
    for (int i = 0; i < N; i++)
      if (tmr_rst_int_n[i] === 1'b0) pulse_cnt[i]++;

  // Behavioural model of the software-visible state
  logic [23:0] m_preset [N];
  logic [7:0]  m_ctrl   [N];
  logic [23:0] m_snap;
  logic [7:0]  m_vec;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_preset[i] = '0;
      m_ctrl[i]   = '0;
    end
    m_snap = '0;
    m_vec  = 8'h40;
  endtask

  function automatic logic [7:0] exp_rd(input int ch, input int off);
    logic [23:0] v;
    v = tmr_value[ch*24 +: 24];
    case (off)
      0: return {~tmr_int_n[ch], m_ctrl[ch][6:0]};
      1: return m_preset[ch][23:16];
      2: return m_preset[ch][15:8];
      3: return m_preset[ch][7:0];
      5: return v[23:16];
`ifdef TIMER_BANK_CTRL_SNAPSHOT_EN
      6: return m_snap[15:8];
      7: return m_snap[7:0];
`else
      6: return v[15:8];
      7: return v[7:0];
`endif
      default: return 8'h00;
    endcase
  endfunction

  // One bus access; entered and left just after a rising edge
  task automatic bus_xfer(input logic is_rd, input int ch, input int off,
                          input logic [7:0] wdata, output logic [7:0] rdata);
    int lat;
    lat  = 0;
    cs_n = 1'b0;
    rw   = is_rd;
    addr = {2'(ch), 3'(off)};
    din  = wdata;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (dtack_n !== 1'b0 && lat < 8);
    chk("dtack_latency", 32'(lat), 32'd2);
    rdata = dout;
    cs_n  = 1'b1;
    @(posedge clk); #1;
    chk("dtack_release", 32'(dtack_n), 32'd1);
  endtask

  task automatic wr(input int ch, input int off, input logic [7:0] data);
    logic [7:0] unused;
    bus_xfer(1'b0, ch, off, data, unused);
    case (off)
      0: m_ctrl[ch]            = data;
      1: m_preset[ch][23:16]   = data;
      2: m_preset[ch][15:8]    = data;
      3: m_preset[ch][7:0]     = data;
      default: ;
    endcase
  endtask

  task automatic rd(input int ch, input int off, output logic [7:0] data);
    logic [23:0] v;
    v = tmr_value[ch*24 +: 24];
    bus_xfer(1'b1, ch, off, 8'h00, data);
`ifdef TIMER_BANK_CTRL_SNAPSHOT_EN
    if (off == 5) m_snap = v;
`endif
  endtask

  task automatic rd_chk(input int ch, input int off);
    logic [7:0] e, d;
    e = exp_rd(ch, off);
    rd(ch, off, d);
    chk($sformatf("rd_ch%0d_off%0d", ch, off), 32'(d), 32'(e));
  endtask

  task automatic chk_regs(input string tag);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("%s_preset%0d", tag, i), 32'(tmr_preset[i*24 +: 24]), 32'(m_preset[i]));
      chk($sformatf("%s_ctrl%0d", tag, i), 32'(tmr_ctrl[i*8 +: 8]), 32'(m_ctrl[i]));
    end
  endtask

  // Arbiter expectation from the stable interrupt inputs, iack_n high
  task automatic chk_irq(input string tag);
    int low;
    low = -1;
    for (int i = N - 1; i >= 0; i--)
      if (tmr_int_n[i] == 1'b0) low = i;
    if (low >= 0) m_vec = 8'(8'h40 + low);
    chk({tag, "_irq_n"}, 32'(irq_n), (low < 0) ? 32'd1 : 32'd0);
    chk({tag, "_vec"}, 32'(irq_vec), 32'(m_vec));
  endtask

  initial begin
    logic [7:0] d;
    int unsigned base [N];

    rst_n = 1'b0; cs_n = 1'b1; rw = 1'b1; addr = '0; din = '0;
    tmr_value = '0; tmr_int_n = '1; iack_n = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dtack", 32'(dtack_n), 32'd1);
    chk("rst_dout", 32'(dout), 32'd0);
    chk("rst_irq_n", 32'(irq_n), 32'd1);
    chk("rst_vec", 32'(irq_vec), 32'h40);
    chk("rst_clr", 32'(tmr_rst_int_n), 32'hF);
    chk("rst_ctrl", tmr_ctrl, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int off = 0; off < 8; off++) begin
      rd(0, off, d);
      chk($sformatf("init_ch0_off%0d", off), 32'(d), 32'h00);
    end

    // Channel 2 preset and enable with a single clear pulse
    wr(2, 1, 8'h12);
    wr(2, 2, 8'h34);
    wr(2, 3, 8'h56);
    for (int i = 0; i < N; i++) base[i] = pulse_cnt[i];
    wr(2, 0, 8'h01);
    repeat (2) @(posedge clk);
    #1;
    chk("ch2_preset", 32'(tmr_preset[71:48]), 32'h123456);
    chk("ch2_ctrl", 32'(tmr_ctrl[23:16]), 32'h01);
    for (int i = 0; i < N; i++)
      chk($sformatf("clr_pulse_ch%0d", i), pulse_cnt[i] - base[i], (i == 2) ? 32'd1 : 32'd0);

    // Channels 1 and 3 pending; two-edge arbiter latency
    wr(1, 0, 8'h01);
    tmr_int_n = 4'b0101;
    @(posedge clk); #1;
    chk("irq_lat1", 32'(irq_n), 32'd1);
    @(posedge clk); #1;
    chk("irq_lat2", 32'(irq_n), 32'd0);
    chk("vec_ch1", 32'(irq_vec), 32'h41);
    m_vec = 8'h41;
    rd(1, 0, d);
    chk("ch1_ctrl_rd", 32'(d), 32'h81);

    // IACK freeze then update one cycle after release
    iack_n    = 1'b0;
    tmr_int_n = 4'b0110;
    repeat (3) @(posedge clk);
    #1;
    chk("iack_frozen_vec", 32'(irq_vec), 32'h41);
    chk("iack_irq_n", 32'(irq_n), 32'd0);
    iack_n = 1'b1;
    @(posedge clk); #1;
    chk("iack_release_vec", 32'(irq_vec), 32'h40);
    m_vec = 8'h40;

    // Value read coherence
    tmr_value[47:24] = 24'hABCDEF;
    rd(1, 5, d);
    chk("snap_hi", 32'(d), 32'hAB);
    tmr_value = '0;
    rd(1, 6, d);
`ifdef TIMER_BANK_CTRL_SNAPSHOT_EN
    chk("snap_mid", 32'(d), 32'hCD);
`else
    chk("live_mid", 32'(d), 32'h00);
`endif
    rd(1, 7, d);
`ifdef TIMER_BANK_CTRL_SNAPSHOT_EN
    chk("snap_lo", 32'(d), 32'hEF);
`else
    chk("live_lo", 32'(d), 32'h00);
`endif

    // Randomized traffic
    for (int it = 0; it < 60; it++) begin
      case ($urandom_range(0, 3))
        0: wr(int'($urandom_range(0, 3)), int'($urandom_range(0, 7)), 8'($urandom));
        1: rd_chk(int'($urandom_range(0, 3)), int'($urandom_range(0, 7)));
        2: tmr_value = {$urandom, $urandom, $urandom};
        default: begin
          tmr_int_n = 4'($urandom);
          repeat (2) @(posedge clk);
          #1;
          chk_irq($sformatf("rand_irq%0d", it));
        end
      endcase
    end
    chk_regs("rand");

    // Reset during ACCESS of a write aborts it
    tmr_int_n = '1;
    cs_n = 1'b0; rw = 1'b0; addr = {2'd3, 3'd1}; din = 8'hAA;
    @(posedge clk); #1;
    rst_n = 1'b0;
    cs_n  = 1'b1;
    model_reset();
    #2;
    chk("midrst_dtack", 32'(dtack_n), 32'd1);
    chk("midrst_dout", 32'(dout), 32'd0);
    chk("midrst_vec", 32'(irq_vec), 32'h40);
    chk("midrst_irq_n", 32'(irq_n), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("post_rst_ch3_preset", 32'(tmr_preset[95:72]), 32'd0);
      chk("post_rst_dtack", 32'(dtack_n), 32'd1);
    end
    chk_regs("post_rst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
